// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared arbiter types and default data widths
package mem_arbiter_pkg;

  localparam int DTYPE_ADDR_W = 32;
  localparam int DTYPE_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } ArbState;

  typedef enum logic {
    ARB_OWNER_I,
    ARB_OWNER_D
  } ArbOwner;

endpackage

// File: rtl/mem_arbiter_grant.sv
// rtl/mem_arbiter_grant.sv - D-priority grant decision with fetch starvation bound
module arb_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ireq_valid,
  input  logic dreq_valid,
  input  logic grant_stb,
  output logic grant_i,
  output logic grant_d
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    grant_d = grant_stb && dreq_valid && !(ireq_valid && starved);
    grant_i = grant_stb && ireq_valid && !grant_d;
  end

  // Counts only D grants that bypassed a waiting fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_i) begin
      starve_cnt <= 4'd0;
    end else if (grant_d) begin
      if (!ireq_valid)
        starve_cnt <= 4'd0;
      else if (!starved)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DTYPE_ADDR_W,
  parameter int DATA_W       = DTYPE_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                ireq_ready,
  output logic                iresp_valid,
  output logic [DATA_W-1:0]   iresp_data,
  input  logic                dreq_valid,
  input  logic                dreq_we,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [DATA_W-1:0]   dreq_wdata,
  input  logic [DATA_W/8-1:0] dreq_wstrb,
  output logic                dreq_ready,
  output logic                dresp_valid,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  ArbState state;
  ArbOwner owner;
  logic    grant_i;
  logic    grant_d;
  logic    resp_fire;

  arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .reset     (reset),
    .ireq_valid(ireq_valid),
    .dreq_valid(dreq_valid),
    .grant_stb (state == ARB_IDLE),
    .grant_i   (grant_i),
    .grant_d   (grant_d)
  );

  assign ireq_ready = grant_i;
  assign dreq_ready = grant_d;

  // Responses outside ARB_RESP are strays (or belong to a request killed by reset).
  assign resp_fire   = (state == ARB_RESP) && mem_resp_valid;
  assign iresp_valid = resp_fire && (owner == ARB_OWNER_I);
  assign dresp_valid = resp_fire && (owner == ARB_OWNER_D);
  assign iresp_data  = iresp_valid ? mem_resp_data : '0;
  assign dresp_data  = dresp_valid ? mem_resp_data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ARB_IDLE;
      owner         <= ARB_OWNER_I;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_d) begin
            owner         <= ARB_OWNER_D;
            mem_req_we    <= dreq_we;
            mem_req_addr  <= dreq_addr;
            mem_req_wdata <= dreq_wdata;
            mem_req_wstrb <= dreq_wstrb;
            mem_req_valid <= 1'b1;
            state         <= ARB_REQ;
          end else if (grant_i) begin
            owner         <= ARB_OWNER_I;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= ireq_addr;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            mem_req_valid <= 1'b1;
            state         <= ARB_REQ;
          end
        end
        ARB_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (mem_resp_valid)
            state <= ARB_IDLE;
        end
        default: begin
          mem_req_valid <= 1'b0;
          state         <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  logic [31:0] dreq_wdata;
  logic [3:0]  dreq_wstrb;
  logic        dreq_ready;
  logic        dresp_valid;
  logic [31:0] dresp_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .dreq_valid    (dreq_valid),
    .dreq_we       (dreq_we),
    .dreq_addr     (dreq_addr),
    .dreq_wdata    (dreq_wdata),
    .dreq_wstrb    (dreq_wstrb),
    .dreq_ready    (dreq_ready),
    .dresp_valid   (dresp_valid),
    .dresp_data    (dresp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wstrb (mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Arbitration order expected with both sides requesting and a limit of 4.
  logic       exp_d   [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  logic [3:0] exp_cnt [10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

  initial begin
    reset = 1'b1;
    ireq_valid = 0; ireq_addr = 0;
    dreq_valid = 0; dreq_we = 0; dreq_addr = 0; dreq_wdata = 0; dreq_wstrb = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    tick(); tick();
    chk("rst_state", 64'(dut.state), 64'(ARB_IDLE));
    chk("rst_cnt", 64'(dut.u_grant.starve_cnt), 0);
    chk("rst_owner", 64'(dut.owner), 64'(ARB_OWNER_I));
    chk("rst_req_valid", 64'(mem_req_valid), 0);
    chk("rst_req_fields", {mem_req_we, mem_req_wstrb, mem_req_addr}, 0);
    chk("rst_req_wdata", 64'(mem_req_wdata), 0);
    chk("rst_readys", {ireq_ready, dreq_ready, iresp_valid, dresp_valid}, 0);
    chk("rst_resp_data", {iresp_data, dresp_data}, 0);
    reset = 1'b0;
    tick();

    // single fetch
    ireq_valid = 1; ireq_addr = 32'h1C000000; mem_req_ready = 1;
    settle();
    chk("f_ireq_ready", 64'(ireq_ready), 1);
    chk("f_dreq_ready", 64'(dreq_ready), 0);
    tick();
    ireq_valid = 0; ireq_addr = 32'hFFFF_FFFF;
    settle();
    chk("f_c1_valid", 64'(mem_req_valid), 1);
    chk("f_c1_addr", 64'(mem_req_addr), 64'h1C000000);
    chk("f_c1_we_strb", {mem_req_we, mem_req_wstrb}, 0);
    chk("f_c1_no_ready", 64'(ireq_ready), 0);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h02800421;
    settle();
    chk("f_c2_iresp", 64'(iresp_valid), 1);
    chk("f_c2_idata", 64'(iresp_data), 64'h02800421);
    chk("f_c2_dresp", 64'(dresp_valid), 0);
    chk("f_c2_req_valid", 64'(mem_req_valid), 0);
    tick();
    mem_resp_valid = 0;
    settle();
    chk("f_c3_iresp", 64'(iresp_valid), 0);
    chk("f_c3_idata_zero", 64'(iresp_data), 0);
    chk("f_c3_idle", 64'(dut.state), 64'(ARB_IDLE));

    // store with three wait cycles
    mem_req_ready = 0;
    dreq_valid = 1; dreq_we = 1; dreq_addr = 32'h100; dreq_wdata = 32'hDEADBEEF; dreq_wstrb = 4'hF;
    settle();
    chk("s_dreq_ready", 64'(dreq_ready), 1);
    chk("s_ireq_ready", 64'(ireq_ready), 0);
    tick();
    dreq_valid = 0; dreq_we = 0; dreq_addr = 32'h555; dreq_wdata = 32'h12345678; dreq_wstrb = 4'h1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_req_ready = 1;
      settle();
      chk($sformatf("s_c%0d_valid", c), 64'(mem_req_valid), 1);
      chk($sformatf("s_c%0d_fields", c), {mem_req_we, mem_req_wstrb, mem_req_addr}, {1'b1, 4'hF, 32'h100});
      chk($sformatf("s_c%0d_wdata", c), 64'(mem_req_wdata), 64'hDEADBEEF);
      tick();
    end
    mem_req_ready = 1;
    settle();
    chk("s_resp_wait_dresp", 64'(dresp_valid), 0);
    chk("s_resp_wait_valid", 64'(mem_req_valid), 0);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h0;
    settle();
    chk("s_dresp", {iresp_valid, dresp_valid}, 2'b01);
    tick();
    mem_resp_valid = 0;
    settle();
    chk("s_dresp_once", 64'(dresp_valid), 0);

    // contention: both requesters hold valid continuously
    ireq_valid = 1; ireq_addr = 32'h1C000040;
    dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h400; dreq_wstrb = 0;
    for (int g = 0; g < 10; g++) begin
      settle();
      chk($sformatf("c%0d_grant", g), {dreq_ready, ireq_ready}, exp_d[g] ? 2'b10 : 2'b01);
      tick();
      chk($sformatf("c%0d_cnt", g), 64'(dut.u_grant.starve_cnt), 64'(exp_cnt[g]));
      chk($sformatf("c%0d_addr", g), 64'(mem_req_addr), exp_d[g] ? 64'h400 : 64'h1C000040);
      tick();
      mem_resp_valid = 1; mem_resp_data = 32'hA000_0000 | 32'(g);
      settle();
      chk($sformatf("c%0d_resp", g), {iresp_valid, dresp_valid}, exp_d[g] ? 2'b01 : 2'b10);
      tick();
      mem_resp_valid = 0;
    end
    ireq_valid = 0; dreq_valid = 0;

    // stray responses in ARB_IDLE and ARB_REQ
    mem_resp_valid = 1; mem_resp_data = 32'hBAD0BAD0;
    settle();
    chk("st_idle_resp", {iresp_valid, dresp_valid}, 0);
    tick();
    chk("st_idle_state", 64'(dut.state), 64'(ARB_IDLE));
    mem_resp_valid = 0; mem_req_ready = 0;
    ireq_valid = 1; ireq_addr = 32'h1C000080;
    tick();
    ireq_valid = 0; mem_resp_valid = 1;
    settle();
    chk("st_req_resp", {iresp_valid, dresp_valid}, 0);
    tick();
    chk("st_req_state", 64'(dut.state), 64'(ARB_REQ));
    chk("st_req_valid", 64'(mem_req_valid), 1);
    mem_resp_valid = 0; mem_req_ready = 1;
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h0000_1111;
    settle();
    chk("st_done_iresp", {iresp_valid, iresp_data}, {1'b1, 32'h0000_1111});
    tick();
    mem_resp_valid = 0;

    // reset while waiting for the response
    ireq_valid = 1; ireq_addr = 32'h1C0000C0;
    tick();
    ireq_valid = 0;
    tick();
    chk("r_in_resp", 64'(dut.state), 64'(ARB_RESP));
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("r_idle", 64'(dut.state), 64'(ARB_IDLE));
    chk("r_req_valid", 64'(mem_req_valid), 0);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'hDEAD0000;
    settle();
    chk("r_late_resp", {iresp_valid, dresp_valid}, 0);
    tick();
    mem_resp_valid = 0;
    chk("r_late_state", 64'(dut.state), 64'(ARB_IDLE));
    dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h300;
    settle();
    chk("r_next_ready", 64'(dreq_ready), 1);
    tick();
    dreq_valid = 0;
    chk("r_next_addr", {mem_req_valid, mem_req_addr}, {1'b1, 32'h300});
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h3333_0300;
    settle();
    chk("r_next_resp", {dresp_valid, dresp_data}, {1'b1, 32'h3333_0300});
    tick();
    mem_resp_valid = 0;

    // back-to-back loads
    dreq_valid = 1; dreq_we = 0; dreq_addr = 32'h200;
    settle();
    chk("b_c0_ready", 64'(dreq_ready), 1);
    tick();
    dreq_addr = 32'h204;
    settle();
    chk("b_c1_addr", 64'(mem_req_addr), 64'h200);
    chk("b_c1_ready", 64'(dreq_ready), 0);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h1111_0200;
    settle();
    chk("b_c2_resp", {dresp_valid, dresp_data}, {1'b1, 32'h1111_0200});
    chk("b_c2_ready", 64'(dreq_ready), 0);
    tick();
    mem_resp_valid = 0;
    settle();
    chk("b_c3_ready", 64'(dreq_ready), 1);
    tick();
    dreq_valid = 0;
    chk("b_c4_addr", 64'(mem_req_addr), 64'h204);
    tick();
    mem_resp_valid = 1; mem_resp_data = 32'h2222_0204;
    settle();
    chk("b_c5_resp", {dresp_valid, dresp_data}, {1'b1, 32'h2222_0204});
    tick();
    mem_resp_valid = 0;
    settle();
    chk("b_c6_quiet", {dresp_valid, iresp_valid}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
